// File: rtl/div_iter.sv
// div_iter: iterative restoring divider for the execute stage.
// Retires BPC quotient bits per clock. Operands and their signs are captured
// on the accept edge. Quotient truncates toward zero and the remainder takes
// the sign of the dividend (MIPS DIV/DIVU semantics).
//
// Parameters:
//   WIDTH  operand/quotient/remainder width (even, >= 4)
//   BPC    quotient bits retired per cycle (1 or 2, WIDTH % BPC == 0)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   signed_i        1 = two's complement operands, 0 = unsigned
//   dividend_i      dividend, sampled on accept
//   divisor_i       divisor, sampled on accept
//   start_i         level request, held until done_o is seen
//   annul_i         cancel; overrides start_i
//   busy_o          high in CALC and FIX
//   done_o          result valid (DONE)
//   quotient_o      quotient
//   remainder_o     remainder
//   div_zero_o      divisor was zero, valid with done_o
module div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             start_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int unsigned STEPS = WIDTH / BPC;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               neg_dd_q, neg_dd_d;
    logic               neg_dv_q, neg_dv_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic [WIDTH-1:0]   mag_dd, mag_dv;
    logic [WIDTH-1:0]   rem_s, quo_s;
    logic [WIDTH:0]     shifted, trial;

    // Operand magnitudes; MIN negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_dd = (signed_i && dividend_i[WIDTH-1]) ? WIDTH'(~dividend_i + 1'b1) : dividend_i;
        mag_dv = (signed_i && divisor_i[WIDTH-1])  ? WIDTH'(~divisor_i + 1'b1)  : divisor_i;
    end

    // BPC restoring steps; quo_s shifts the dividend out as quotient bits shift in.
    always_comb begin
        rem_s   = rem_q;
        quo_s   = quo_q;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            shifted = {rem_s, quo_s[WIDTH-1]};
            trial   = shifted - {1'b0, dvs_q};
            rem_s   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_s   = {quo_s[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        neg_dd_d    = neg_dd_q;
        neg_dv_d    = neg_dv_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        busy_d      = busy_q;
        done_d      = done_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    sgn_d    = signed_i;
                    neg_dd_d = dividend_i[WIDTH-1];
                    neg_dv_d = divisor_i[WIDTH-1];
                    if (divisor_i == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        dz_d        = 1'b1;
                        quotient_d  = '0;
                        remainder_d = '0;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = mag_dd;
                        dvs_d   = mag_dv;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_s;
                quo_d = quo_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = (sgn_q && (neg_dd_q ^ neg_dv_q)) ? WIDTH'(~quo_q + 1'b1) : quo_q;
                remainder_d = (sgn_q && neg_dd_q) ? WIDTH'(~rem_q + 1'b1) : rem_q;
                dz_d        = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (!start_i) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b0;
                    dz_d        = 1'b0;
                    quotient_d  = '0;
                    remainder_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel beats every other transition once an operation is in flight.
        if (annul_i && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            dz_d        = 1'b0;
            quotient_d  = '0;
            remainder_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            neg_dd_q    <= 1'b0;
            neg_dv_q    <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            neg_dd_q    <= neg_dd_d;
            neg_dv_q    <= neg_dv_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign div_zero_o  = dz_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: three instances (32/1, 32/2, 8/1) sharing
// clock, reset and operand buses, each with its own start line.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sgn;
    logic [31:0] dd, dv;
    logic [2:0]  start_v;
    logic        annul;

    logic        busy_a, done_a, dz_a;
    logic [31:0] q_a, r_a;
    logic        busy_b, done_b, dz_b;
    logic [31:0] q_b, r_b;
    logic        busy_c, done_c, dz_c;
    logic [7:0]  q_c, r_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .BPC(1)) u_a (
        .clk(clk), .rst(rst), .signed_i(sgn), .dividend_i(dd), .divisor_i(dv),
        .start_i(start_v[0]), .annul_i(annul), .busy_o(busy_a), .done_o(done_a),
        .quotient_o(q_a), .remainder_o(r_a), .div_zero_o(dz_a)
    );

    div_iter #(.WIDTH(32), .BPC(2)) u_b (
        .clk(clk), .rst(rst), .signed_i(sgn), .dividend_i(dd), .divisor_i(dv),
        .start_i(start_v[1]), .annul_i(1'b0), .busy_o(busy_b), .done_o(done_b),
        .quotient_o(q_b), .remainder_o(r_b), .div_zero_o(dz_b)
    );

    div_iter #(.WIDTH(8), .BPC(1)) u_c (
        .clk(clk), .rst(rst), .signed_i(sgn), .dividend_i(dd[7:0]), .divisor_i(dv[7:0]),
        .start_i(start_v[2]), .annul_i(1'b0), .busy_o(busy_c), .done_o(done_c),
        .quotient_o(q_c), .remainder_o(r_c), .div_zero_o(dz_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [31:0] get_q(input int d);
        case (d)
            0: return q_a;
            1: return q_b;
            default: return {24'h0, q_c};
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int d);
        case (d)
            0: return r_a;
            1: return r_b;
            default: return {24'h0, r_c};
        endcase
    endfunction

    function automatic logic get_dz(input int d);
        case (d)
            0: return dz_a;
            1: return dz_b;
            default: return dz_c;
        endcase
    endfunction

    // Start a request on instance d; operands are scrambled after the accept
    // edge. Returns edges until done_o, busy after edge 1 and busy just before done.
    task automatic run(input int d, input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic b1, output logic bprev);
        sgn = s; dd = a; dv = b;
        start_v[d] = 1'b1;
        lat = 0; b1 = 1'b0; bprev = 1'b0;
        do begin
            bprev = get_busy(d);
            step();
            lat++;
            if (lat == 1) begin
                b1 = get_busy(d);
                dd = 32'hDEAD_BEEF; dv = 32'h0; sgn = ~s;
            end
        end while (!get_done(d) && lat < 60);
    endtask

    task automatic drop(input int d);
        start_v[d] = 1'b0;
        step();
    endtask

    int   lat;
    logic b1, bp;
    int   seen;

    initial begin
        rst = 1'b1; sgn = 1'b0; dd = '0; dv = '0; start_v = '0; annul = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_q",    q_a, 32'd0);
        chk("rst_r",    r_a, 32'd0);
        chk("rst_dz",   32'(dz_a), 32'd0);

        // 100 / 7 unsigned, start held through DONE
        run(0, 1'b0, 32'd100, 32'd7, lat, b1, bp);
        chk("u100_7_lat",   32'(lat), 32'd34);
        chk("u100_7_b1",    32'(b1), 32'd1);
        chk("u100_7_bpre",  32'(bp), 32'd1);
        chk("u100_7_busy",  32'(busy_a), 32'd0);
        chk("u100_7_q",     q_a, 32'd14);
        chk("u100_7_r",     r_a, 32'd2);
        chk("u100_7_dz",    32'(dz_a), 32'd0);
        step();
        chk("hold_done",    32'(done_a), 32'd1);
        chk("hold_q",       q_a, 32'd14);
        drop(0);
        chk("drop_done",    32'(done_a), 32'd0);
        chk("drop_q",       q_a, 32'd0);
        chk("drop_r",       r_a, 32'd0);

        // signed cases
        run(0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, b1, bp);
        chk("sm7_2_q", q_a, 32'hFFFF_FFFD);
        chk("sm7_2_r", r_a, 32'hFFFF_FFFF);
        drop(0);
        run(0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, b1, bp);
        chk("s7_m2_q", q_a, 32'hFFFF_FFFD);
        chk("s7_m2_r", r_a, 32'd1);
        drop(0);
        run(0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, b1, bp);
        chk("sm100_m7_q", q_a, 32'd14);
        chk("sm100_m7_r", r_a, 32'hFFFF_FFFE);
        drop(0);
        run(0, 1'b0, 32'hFFFF_FFFF, 32'd16, lat, b1, bp);
        chk("umax_16_q", q_a, 32'h0FFF_FFFF);
        chk("umax_16_r", r_a, 32'd15);
        drop(0);

        // divide by zero
        run(0, 1'b0, 32'h1234, 32'd0, lat, b1, bp);
        chk("dz_lat",  32'(lat), 32'd1);
        chk("dz_flag", 32'(dz_a), 32'd1);
        chk("dz_q",    q_a, 32'd0);
        chk("dz_r",    r_a, 32'd0);
        drop(0);
        chk("dz_drop_done", 32'(done_a), 32'd0);
        chk("dz_drop_flag", 32'(dz_a), 32'd0);

        // annul at edge 10 of an operation
        sgn = 1'b0; dd = 32'd20; dv = 32'd3; start_v[0] = 1'b1;
        step();
        repeat (8) step();
        annul = 1'b1;
        step();
        chk("annul_busy", 32'(busy_a), 32'd0);
        chk("annul_done", 32'(done_a), 32'd0);
        annul = 1'b0; start_v[0] = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (done_a) seen++;
        end
        chk("annul_no_done", 32'(seen), 32'd0);
        run(0, 1'b0, 32'd9, 32'd3, lat, b1, bp);
        chk("after_annul_q", q_a, 32'd3);
        chk("after_annul_r", r_a, 32'd0);

        // annul while in DONE with start still high
        annul = 1'b1;
        step();
        chk("annul_done_st", 32'(done_a), 32'd0);
        chk("annul_done_q",  q_a, 32'd0);
        annul = 1'b0;
        drop(0);

        // BPC=2 overflow wrap and a plain case
        run(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1, bp);
        chk("b_ovf_lat", 32'(lat), 32'd18);
        chk("b_ovf_q",   q_b, 32'h8000_0000);
        chk("b_ovf_r",   r_b, 32'd0);
        chk("b_ovf_dz",  32'(dz_b), 32'd0);
        drop(1);
        run(1, 1'b1, 32'd100, 32'd7, lat, b1, bp);
        chk("b_100_7_q", q_b, 32'd14);
        chk("b_100_7_r", r_b, 32'd2);
        drop(1);

        // reset in the middle of CALC
        sgn = 1'b0; dd = 32'd100; dv = 32'd7; start_v[0] = 1'b1;
        step();
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mrst_busy", 32'(busy_a), 32'd0);
        chk("mrst_done", 32'(done_a), 32'd0);
        chk("mrst_q",    q_a, 32'd0);
        rst = 1'b0; start_v[0] = 1'b0;
        step();
        chk("mrst_idle_busy", 32'(busy_a), 32'd0);

        // WIDTH=8
        run(2, 1'b0, 32'd255, 32'd16, lat, b1, bp);
        chk("c_255_16_lat", 32'(lat), 32'd10);
        chk("c_255_16_q",   get_q(2), 32'd15);
        chk("c_255_16_r",   get_r(2), 32'd15);
        chk("c_255_16_dz",  32'(get_dz(2)), 32'd0);
        drop(2);
        run(2, 1'b1, 32'h80, 32'h03, lat, b1, bp);
        chk("c_m128_3_q", get_q(2), 32'hD6);
        chk("c_m128_3_r", get_r(2), 32'hFE);
        drop(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
